// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_e;

  // HILO flag layout: [2] writes HILO, [1:0] HI/LO mask
  localparam int HILO_WR      = 2;
  localparam int HILO_MASK_HI = 1;
  localparam int HILO_MASK_LO = 0;

endpackage

// File: rtl/hazard_div_fsm.sv
// Divider busy tracker: IDLE -> BUSY (DIV_CYCLES cycles) -> DONE (1 cycle) -> IDLE.
module hazard_div_fsm
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 36,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic hold,
  input  logic abort,
  output logic busy,
  output logic done
);

  div_state_e stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  // abort beats hold; hold freezes state and counter, which also defers a start
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    if (abort) begin
      stateNext = IDLE;
    end else if (!hold) begin
      case (stateReg)
        IDLE: begin
          if (start) begin
            stateNext = BUSY;
            cntNext   = CNT_W'(DIV_CYCLES - 1);
          end
        end
        BUSY: begin
          if (cntReg == '0) stateNext = DONE;
          else              cntNext   = cntReg - CNT_W'(1);
        end
        DONE:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  assign busy = (stateReg == BUSY);
  assign done = (stateReg == DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall/flush controller for the 5-stage pipeline with forwarding and divider stall.
// Optional HAZARD_STATS_EN enables saturating stall/divider cycle counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 36,
  parameter int CNT_W      = 6,
  parameter int STAT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic              jrD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              memtoregE,
  input  logic              memtoregM,
  input  logic [2:0]        flagE,
  input  logic [2:0]        flagM,
  input  logic [2:0]        flagW,
  input  logic              div_startE,
  input  logic              mem_stall_req,
  input  logic              except_flush,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              div_busy,
  output logic              div_done,
  output logic [STAT_W-1:0] stat_stall_cyc,
  output logic [STAT_W-1:0] stat_div_cyc
);

  function automatic logic regHit(input logic [REG_AW-1:0] r, input logic [REG_AW-1:0] w);
    return (r != '0) && (r == w);
  endfunction

  function automatic fwd_sel_e fwdSel(input logic [REG_AW-1:0] r,
                                      input logic hiloM, input logic hiloW,
                                      input logic [REG_AW-1:0] wM, input logic rwM,
                                      input logic [REG_AW-1:0] wW, input logic rwW);
    if (hiloM)                return FWD_M;
    if (hiloW)                return FWD_W;
    if (r == '0)              return FWD_RF;
    if ((r == wM) && rwM)     return FWD_M;
    if ((r == wW) && rwW)     return FWD_W;
    return FWD_RF;
  endfunction

  logic hiloHitM, hiloHitW, useRs, useRt, lwStall, brStall, fsmBusy, fsmDone;

  // a HILO read in E (no HILO write) overlapping a later-stage HILO write
  assign hiloHitM = ((flagE[HILO_MASK_HI:HILO_MASK_LO] & flagM[HILO_MASK_HI:HILO_MASK_LO]) != '0)
                    && !flagE[HILO_WR] && flagM[HILO_WR];
  assign hiloHitW = ((flagE[HILO_MASK_HI:HILO_MASK_LO] & flagW[HILO_MASK_HI:HILO_MASK_LO]) != '0)
                    && !flagE[HILO_WR] && flagW[HILO_WR];

  assign useRs = branchD | jrD;
  assign useRt = branchD;

  assign lwStall = memtoregE & regwriteE & (regHit(rsD, writeregE) | regHit(rtD, writeregE));
  assign brStall = (regwriteE & ((useRs & regHit(rsD, writeregE)) | (useRt & regHit(rtD, writeregE))))
                 | (memtoregM & ((useRs & regHit(rsD, writeregM)) | (useRt & regHit(rtD, writeregM))));

  hazard_div_fsm #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) uDivFsm (
    .clk   (clk),
    .rst   (rst),
    .start (div_startE),
    .hold  (mem_stall_req),
    .abort (except_flush),
    .busy  (fsmBusy),
    .done  (fsmDone)
  );

  assign div_busy = fsmBusy;
  assign div_done = fsmDone;

  always_comb begin
    {stallF, stallD, stallE, stallM} = '0;
    {flushD, flushE, flushM, flushW} = '0;
    forwardaD = 1'b0;
    forwardbD = 1'b0;
    forwardaE = FWD_RF;
    forwardbE = FWD_RF;
    if (rst) begin
      {flushD, flushE, flushM, flushW} = '1;
    end else begin
      forwardaE = fwdSel(rsE, hiloHitM, hiloHitW, writeregM, regwriteM, writeregW, regwriteW);
      forwardbE = fwdSel(rtE, 1'b0, 1'b0, writeregM, regwriteM, writeregW, regwriteW);
      forwardaD = regHit(rsD, writeregM) & regwriteM & !memtoregM;
      forwardbD = regHit(rtD, writeregM) & regwriteM & !memtoregM;
      if (except_flush) begin
        {flushD, flushE, flushM, flushW} = '1;
      end else if (mem_stall_req) begin
        {stallF, stallD, stallE, stallM} = '1;
        flushW = 1'b1;
      end else if (fsmBusy) begin
        {stallF, stallD, stallE} = '1;
        flushM = 1'b1;
      end else if (lwStall | brStall) begin
        {stallF, stallD} = '1;
        flushE = 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] statStallReg, statDivReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      statStallReg <= '0;
      statDivReg   <= '0;
    end else begin
      if (stallF && (statStallReg != '1)) statStallReg <= statStallReg + STAT_W'(1);
      if (fsmBusy && (statDivReg != '1))  statDivReg   <= statDivReg + STAT_W'(1);
    end
  end

  assign stat_stall_cyc = statStallReg;
  assign stat_div_cyc   = statDivReg;
`else
  assign stat_stall_cyc = '0;
  assign stat_div_cyc   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic vs a cycle model.
module tb_hazard_ctrl;

  localparam int DIVC = 36;
  localparam longint STAT_MAX = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic branchD, jrD, regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic [2:0] flagE, flagM, flagW;
  logic div_startE, mem_stall_req, except_flush;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;
  logic forwardaD, forwardbD, div_busy, div_done;
  logic [1:0] forwardaE, forwardbE;
  logic [31:0] stat_stall_cyc, stat_div_cyc;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .flagE(flagE), .flagM(flagM), .flagW(flagW),
    .div_startE(div_startE), .mem_stall_req(mem_stall_req), .except_flush(except_flush),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE), .forwardbE(forwardbE),
    .div_busy(div_busy), .div_done(div_done),
    .stat_stall_cyc(stat_stall_cyc), .stat_div_cyc(stat_div_cyc)
  );

  int checks = 0;
  int failures = 0;
  bit checkEn = 0;

  // model state: divider busy cycles still owed, one-cycle done flag, stats
  int     mBusyLeft = 0;
  bit     mDone = 0;
  longint mStatStall = 0;
  longint mStatDiv = 0;

  typedef struct packed {
    logic sF, sD, sE, sM, fD, fE, fM, fW, faD, fbD;
    logic [1:0] faE, fbE;
    logic busy, done;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] r, input logic [4:0] w);
    return (r != 0) && (r == w);
  endfunction

  function automatic logic [1:0] fwdExp(input logic [4:0] r, input bit hm, input bit hw);
    if (hm) return 2'b10;
    if (hw) return 2'b01;
    if (r == 0) return 2'b00;
    if (r == writeregM && regwriteM) return 2'b10;
    if (r == writeregW && regwriteW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t expected();
    exp_t e;
    bit hm, hw, lw, br;
    e = '0;
    e.busy = (mBusyLeft > 0);
    e.done = mDone;
    if (rst) begin
      {e.fD, e.fE, e.fM, e.fW} = 4'b1111;
      return e;
    end
    hm = ((flagE[1:0] & flagM[1:0]) != 0) && !flagE[2] && flagM[2];
    hw = ((flagE[1:0] & flagW[1:0]) != 0) && !flagE[2] && flagW[2];
    e.faE = fwdExp(rsE, hm, hw);
    e.fbE = fwdExp(rtE, 1'b0, 1'b0);
    e.faD = hit(rsD, writeregM) && regwriteM && !memtoregM;
    e.fbD = hit(rtD, writeregM) && regwriteM && !memtoregM;
    lw = memtoregE && regwriteE && (hit(rsD, writeregE) || hit(rtD, writeregE));
    br = (branchD && ((regwriteE && (hit(rsD, writeregE) || hit(rtD, writeregE))) ||
                      (memtoregM && (hit(rsD, writeregM) || hit(rtD, writeregM))))) ||
         (jrD && ((regwriteE && hit(rsD, writeregE)) || (memtoregM && hit(rsD, writeregM))));
    if (except_flush) {e.fD, e.fE, e.fM, e.fW} = 4'b1111;
    else if (mem_stall_req) begin {e.sF, e.sD, e.sE, e.sM} = 4'b1111; e.fW = 1; end
    else if (e.busy) begin {e.sF, e.sD, e.sE} = 3'b111; e.fM = 1; end
    else if (lw || br) begin {e.sF, e.sD} = 2'b11; e.fE = 1; end
    return e;
  endfunction

  // model state advance on the same edge the DUT registers
  always @(posedge clk) begin
    exp_t e;
    e = expected();
    if (rst) begin
      mBusyLeft = 0; mDone = 0; mStatStall = 0; mStatDiv = 0;
    end else begin
      if (e.sF && mStatStall != STAT_MAX) mStatStall++;
      if (mBusyLeft > 0 && mStatDiv != STAT_MAX) mStatDiv++;
      if (except_flush) begin
        mBusyLeft = 0; mDone = 0;
      end else if (!mem_stall_req) begin
        if (mBusyLeft > 0) begin
          mBusyLeft--;
          if (mBusyLeft == 0) mDone = 1;
        end else if (mDone) mDone = 0;
        else if (div_startE) mBusyLeft = DIVC;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (checkEn) begin
      e = expected();
      check("stallF", stallF, e.sF);       check("stallD", stallD, e.sD);
      check("stallE", stallE, e.sE);       check("stallM", stallM, e.sM);
      check("flushD", flushD, e.fD);       check("flushE", flushE, e.fE);
      check("flushM", flushM, e.fM);       check("flushW", flushW, e.fW);
      check("forwardaD", forwardaD, e.faD); check("forwardbD", forwardbD, e.fbD);
      check("forwardaE", forwardaE, e.faE); check("forwardbE", forwardbE, e.fbE);
      check("div_busy", div_busy, e.busy); check("div_done", div_done, e.done);
`ifdef HAZARD_STATS_EN
      check("stat_stall_cyc", stat_stall_cyc, mStatStall[31:0]);
      check("stat_div_cyc", stat_div_cyc, mStatDiv[31:0]);
`else
      check("stat_stall_cyc", stat_stall_cyc, 0);
      check("stat_div_cyc", stat_div_cyc, 0);
`endif
    end
  end

  task automatic clearIn();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {branchD, jrD, regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
    {flagE, flagM, flagW} = '0;
    {div_startE, mem_stall_req, except_flush} = '0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  // run one divide; optionally hold memory for 3 cycles from the 10th busy cycle
  task automatic runDiv(input bit withMem, input int expBusy, input string tag);
    int busyCnt, stallCnt, doneCnt;
    busyCnt = 0; stallCnt = 0; doneCnt = 0;
    clearIn();
    div_startE = 1'b1;
    nextCycle();
    div_startE = 1'b0;
    for (int c = 0; c < 80; c++) begin
      mem_stall_req = withMem && (busyCnt >= 10) && (busyCnt < 13);
      #1;
      if (div_busy) busyCnt++;
      if (stallF && stallD && stallE) stallCnt++;
      if (div_done) doneCnt++;
      nextCycle();
    end
    mem_stall_req = 1'b0;
    check({tag, "_busy_cycles"}, busyCnt, expBusy);
    check({tag, "_stall_cycles"}, stallCnt, expBusy);
    check({tag, "_done_pulses"}, doneCnt, 1);
`ifdef HAZARD_STATS_EN
    check({tag, "_stat_div"}, stat_div_cyc, expBusy);
    check({tag, "_stat_stall"}, stat_stall_cyc, expBusy);
`else
    check({tag, "_stat_div"}, stat_div_cyc, 0);
    check({tag, "_stat_stall"}, stat_stall_cyc, 0);
`endif
    $display("div run %s: busy=%0d stall=%0d done=%0d", tag, busyCnt, stallCnt, doneCnt);
  endtask

  initial begin
    int busySeen, doneSeen;
    clearIn();
    rst = 1'b1;
    nextCycle();
    checkEn = 1;
    #1;
    check("rst_flushD", flushD, 1); check("rst_flushW", flushW, 1);
    check("rst_stallF", stallF, 0); check("rst_busy", div_busy, 0);
    check("rst_stat", stat_div_cyc, 0);
    nextCycle();
    rst = 1'b0;

    // EX->EX forwarding and HILO forwarding
    rsE = 8; writeregM = 8; regwriteM = 1; #1;
    check("fwdE_M", forwardaE, 2'b10); check("flushD_idle", flushD, 0);
    nextCycle();
    writeregM = 0; regwriteM = 0; writeregW = 8; regwriteW = 1; #1;
    check("fwdE_W", forwardaE, 2'b01);
    nextCycle();
    rsE = 0; writeregM = 0; regwriteM = 1; writeregW = 0; #1;
    check("fwdE_x0", forwardaE, 2'b00);
    nextCycle();
    flagE = 3'b001; flagM = 3'b101; #1;
    check("fwdE_hilo", forwardaE, 2'b10); check("fwdbE_nohilo", forwardbE, 2'b00);
    $display("txn fwdE done");

    // load-use
    nextCycle(); clearIn();
    memtoregE = 1; regwriteE = 1; writeregE = 9; rtD = 9; #1;
    check("lw_stallF", stallF, 1); check("lw_stallD", stallD, 1);
    check("lw_flushE", flushE, 1); check("lw_stallE", stallE, 0);
    nextCycle(); clearIn();
    memtoregM = 1; regwriteM = 1; writeregM = 9; rtE = 9; #1;
    check("lw_fwdbE", forwardbE, 2'b10); check("lw_nostall", stallF, 0);
    $display("txn load-use done");

    // branch / jr
    nextCycle(); clearIn();
    branchD = 1; rsD = 4; regwriteE = 1; writeregE = 4; #1;
    check("br_stall", stallF, 1); check("br_flushE", flushE, 1);
    nextCycle(); clearIn();
    branchD = 1; rsD = 4; writeregM = 4; regwriteM = 1; #1;
    check("br_fwdaD", forwardaD, 1); check("br_nostall", stallF, 0);
    nextCycle(); clearIn();
    jrD = 1; rtD = 5; regwriteE = 1; writeregE = 5; #1;
    check("jr_rt_ignored", stallF, 0);
    jrD = 0; branchD = 1; #1;
    check("br_rt_stall", stallF, 1);
    $display("txn branch done");

    // divider, clean and with a memory hold mid-busy
    nextCycle(); clearIn(); doReset();
    runDiv(1'b0, DIVC, "div");
    doReset();
    runDiv(1'b1, DIVC + 3, "divmem");

    // exception aborts a divide
    doReset(); clearIn();
    div_startE = 1;
    nextCycle();
    div_startE = 0;
    for (int c = 0; c < 10; c++) nextCycle();
    except_flush = 1; #1;
    check("exc_flushD", flushD, 1); check("exc_flushM", flushM, 1);
    check("exc_flushW", flushW, 1); check("exc_stallF", stallF, 0);
    nextCycle();
    except_flush = 0; #1;
    check("exc_busy_off", div_busy, 0);
    busySeen = 0; doneSeen = 0;
    for (int c = 0; c < 45; c++) begin
      if (div_done) doneSeen++;
      if (div_busy) busySeen++;
      nextCycle();
    end
    check("exc_no_done", doneSeen, 0); check("exc_no_busy", busySeen, 0);
    $display("txn exception done");

    // randomized traffic
    doReset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom % 300) == 0;
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      {branchD, jrD, regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = 7'($urandom);
      flagE = 3'($urandom); flagM = 3'($urandom); flagW = 3'($urandom);
      div_startE = ($urandom % 15) == 0;
      mem_stall_req = (($urandom % 8) == 0) && !mDone;
      except_flush = ($urandom % 60) == 0;
      nextCycle();
    end
    clearIn();
    nextCycle();
    checkEn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
